md5_hex_sender: RTL

Upstream feeder for the `usart` transmitter. It captures a finished MD5 digest and converts it to lowercase ASCII hexadecimal, most significant nibble first. It then pushes one character at a time into the `usart` byte handshake (`bytetosend`/`send`/`sent`). It sits between the MD5 core's result register and the UART so that digests appear on the serial line as readable text.

---
 rtl/md5_hex_sender.sv | 137 +++++++++++++
 1 files changed

// File: rtl/md5_hex_sender.sv
// md5_hex_sender: captures a finished MD5 digest and streams it to the usart
// byte handshake as lowercase ASCII hex, most significant nibble first.
// Optional build macro MD5_HEX_SENDER_CRLF_EN appends CR (8'h0D) and LF (8'h0A)
// after the last hex character; without it exactly NCHARS characters go out.
//
// state  | meaning
// IDLE   | waiting for digest_valid; busy low
// ISSUE  | bytetosend valid; send fires on the first cycle sent is high
// SETTLE | one dead cycle so the UART can drop sent
// WAIT   | character in flight; wait for sent to return high
// FINISH | one-cycle done pulse, back to IDLE next
module md5_hex_sender #(
    parameter int DIGEST_BITS = 128,
    parameter int NCHARS      = DIGEST_BITS / 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DIGEST_BITS-1:0] digest,
    input  logic                   digest_valid,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             bytetosend,
    output logic                   send,
    input  logic                   sent
);

    localparam int CW = $clog2(NCHARS + 2);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef MD5_HEX_SENDER_CRLF_EN
    localparam logic [CW-1:0] CNT_CR   = CW'(NCHARS);
    localparam logic [CW-1:0] CNT_LF   = CW'(NCHARS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NCHARS + 1);
`else
    localparam logic [CW-1:0] CNT_LAST = CW'(NCHARS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t                 state_q;
    logic [DIGEST_BITS-1:0] shift_q;
    logic [DIGEST_BITS-1:0] shift_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [7:0]             byte_q;
    logic [7:0]             byte_d;
    logic                   busy_q;
    logic                   done_q;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return {4'h3, nib};
        end
        return 8'h57 + {4'h0, nib};
    endfunction

    // Next character: the nibble that becomes the top one after a 4-bit shift,
    // or the line terminator once the hex characters are exhausted.
    always_comb begin
        shift_d = shift_q << 4;
        cnt_d   = cnt_q + CNT_ONE;
        byte_d  = hex_ascii(shift_d[DIGEST_BITS-1 -: 4]);
`ifdef MD5_HEX_SENDER_CRLF_EN
        if (cnt_d == CNT_CR) begin
            byte_d = 8'h0D;
        end else if (cnt_d == CNT_LF) begin
            byte_d = 8'h0A;
        end
`endif
    end

    // Sequencing FSM; bytetosend only changes on the edge that enters ISSUE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            byte_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (digest_valid) begin
                        shift_q <= digest;
                        cnt_q   <= '0;
                        byte_q  <= hex_ascii(digest[DIGEST_BITS-1 -: 4]);
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (sent) begin
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (sent) begin
                        if (cnt_q == CNT_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                            byte_q  <= byte_d;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // send must fire in the same cycle sent is seen high in ISSUE, so it is
    // decoded from the state register and the live sent flag.
    assign send       = (state_q == S_ISSUE) && sent;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bytetosend = byte_q;

endmodule
